// File: rtl/dccm_arbiter_pkg.sv
// rtl/dccm_arbiter_pkg.sv - shared types and defaults for the DCCM arbiter
package dccm_arbiter_pkg;

  localparam int DCCM_ARB_XLEN       = 32;
  localparam int DCCM_ARB_ADDR_W     = 16;
  localparam int DCCM_ARB_STARVE_MAX = 8;

  typedef struct packed {
    logic                         we;
    logic [DCCM_ARB_ADDR_W-1:0]   addr;
    logic [DCCM_ARB_XLEN/8-1:0]   wmask;
    logic [DCCM_ARB_XLEN-1:0]     wdata;
  } dccm_req_t;

  typedef enum logic {
    ARB_LSU_PRI,
    ARB_DMA_FORCE
  } arb_state_e;

  typedef enum logic {
    RSP_LSU,
    RSP_DMA
  } rsp_owner_e;

endpackage

// File: rtl/dccm_arb_starve_ctr.sv
// rtl/dccm_arb_starve_ctr.sv - saturating DMA starvation counter with threshold flag
module dccm_arb_starve_ctr
  import dccm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DCCM_ARB_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic reached
);

  logic [7:0] count;
  logic [7:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc && (count != 8'hFF)) begin
      count_nxt = count + 8'd1;
    end
  end

  // Flag is taken from the next value so the force state lines up with the edge the count lands.
  assign reached = (32'(count_nxt) >= STARVE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dccm_arbiter.sv
// rtl/dccm_arbiter.sv - LSU-priority DCCM arbiter with DMA starvation guard and one-deep response path
module dccm_arbiter
  import dccm_arbiter_pkg::*;
#(
  parameter int XLEN        = DCCM_ARB_XLEN,
  parameter int DCCM_ADDR_W = DCCM_ARB_ADDR_W,
  parameter int STARVE_MAX  = DCCM_ARB_STARVE_MAX
) (
  input  logic                   clk,
  input  logic                   rst_n,

  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic                   lsu_req_we,
  input  logic [DCCM_ADDR_W-1:0] lsu_req_addr,
  input  logic [XLEN/8-1:0]      lsu_req_wmask,
  input  logic [XLEN-1:0]        lsu_req_wdata,
  output logic                   lsu_rsp_valid,
  output logic [XLEN-1:0]        lsu_rsp_rdata,

  input  logic                   dma_req_valid,
  output logic                   dma_req_ready,
  input  logic                   dma_req_we,
  input  logic [DCCM_ADDR_W-1:0] dma_req_addr,
  input  logic [XLEN/8-1:0]      dma_req_wmask,
  input  logic [XLEN-1:0]        dma_req_wdata,
  output logic                   dma_rsp_valid,
  output logic [XLEN-1:0]        dma_rsp_rdata,

  output logic                   dccm_en,
  output logic                   dccm_we,
  output logic [DCCM_ADDR_W-1:0] dccm_addr,
  output logic [XLEN/8-1:0]      dccm_wmask,
  output logic [XLEN-1:0]        dccm_wdata,
  input  logic [XLEN-1:0]        dccm_rdata
);

  arb_state_e arb_state;
  rsp_owner_e rsp_owner;
  logic       rsp_pend;
  logic       rsp_is_read;
  logic       lsu_gnt;
  logic       dma_gnt;
  logic       starve_hit;

  // Readies are held low during reset so nothing reaches the macro while rst_n is asserted.
  assign lsu_req_ready = rst_n && (arb_state == ARB_LSU_PRI);
  assign dma_req_ready = rst_n && ((arb_state == ARB_DMA_FORCE) || !lsu_req_valid);

  assign lsu_gnt = lsu_req_valid && lsu_req_ready;
  assign dma_gnt = dma_req_valid && dma_req_ready && !lsu_gnt;

  dccm_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (dma_req_valid && !dma_gnt),
    .clr     (dma_gnt || !dma_req_valid),
    .reached (starve_hit)
  );

  always_comb begin
    dccm_en    = 1'b0;
    dccm_we    = 1'b0;
    dccm_addr  = '0;
    dccm_wmask = '0;
    dccm_wdata = '0;
    if (lsu_gnt) begin
      dccm_en    = 1'b1;
      dccm_we    = lsu_req_we;
      dccm_addr  = lsu_req_addr;
      dccm_wmask = lsu_req_we ? lsu_req_wmask : '0;
      dccm_wdata = lsu_req_wdata;
    end else if (dma_gnt) begin
      dccm_en    = 1'b1;
      dccm_we    = dma_req_we;
      dccm_addr  = dma_req_addr;
      dccm_wmask = dma_req_we ? dma_req_wmask : '0;
      dccm_wdata = dma_req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state <= ARB_LSU_PRI;
    end else begin
      case (arb_state)
        ARB_LSU_PRI:   if (starve_hit) arb_state <= ARB_DMA_FORCE;
        ARB_DMA_FORCE: if (dma_gnt || !dma_req_valid) arb_state <= ARB_LSU_PRI;
        default:       arb_state <= ARB_LSU_PRI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend    <= 1'b0;
      rsp_owner   <= RSP_LSU;
      rsp_is_read <= 1'b0;
    end else begin
      rsp_pend    <= lsu_gnt || dma_gnt;
      rsp_owner   <= dma_gnt ? RSP_DMA : RSP_LSU;
      rsp_is_read <= dma_gnt ? !dma_req_we : !lsu_req_we;
    end
  end

  assign lsu_rsp_valid = rsp_pend && (rsp_owner == RSP_LSU);
  assign dma_rsp_valid = rsp_pend && (rsp_owner == RSP_DMA);
  assign lsu_rsp_rdata = (lsu_rsp_valid && rsp_is_read) ? dccm_rdata : '0;
  assign dma_rsp_rdata = (dma_rsp_valid && rsp_is_read) ? dccm_rdata : '0;

endmodule

// File: tb/tb_dccm_arbiter.sv
// tb/tb_dccm_arbiter.sv - randomized self-checking bench for dccm_arbiter
module tb_dccm_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = 16;
  localparam int SMAX = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            lsu_req_valid, lsu_req_ready, lsu_req_we;
  logic [AW-1:0]   lsu_req_addr;
  logic [3:0]      lsu_req_wmask;
  logic [31:0]     lsu_req_wdata;
  logic            lsu_rsp_valid;
  logic [31:0]     lsu_rsp_rdata;
  logic            dma_req_valid, dma_req_ready, dma_req_we;
  logic [AW-1:0]   dma_req_addr;
  logic [3:0]      dma_req_wmask;
  logic [31:0]     dma_req_wdata;
  logic            dma_rsp_valid;
  logic [31:0]     dma_rsp_rdata;
  logic            dccm_en, dccm_we;
  logic [AW-1:0]   dccm_addr;
  logic [3:0]      dccm_wmask;
  logic [31:0]     dccm_wdata;
  logic [31:0]     dccm_rdata;

  always #5 clk = ~clk;

  dccm_arbiter #(.XLEN(XLEN), .DCCM_ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wmask(lsu_req_wmask), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
    .dma_req_addr(dma_req_addr), .dma_req_wmask(dma_req_wmask), .dma_req_wdata(dma_req_wdata),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
    .dccm_en(dccm_en), .dccm_we(dccm_we), .dccm_addr(dccm_addr),
    .dccm_wmask(dccm_wmask), .dccm_wdata(dccm_wdata), .dccm_rdata(dccm_rdata)
  );

  function automatic logic [31:0] pat(int i);
    return 32'(i + 1) * 32'h9E3779B9;
  endfunction

  // Memory macro stand-in: one-cycle read latency, reloaded with a known pattern while in reset.
  logic [31:0] macro_mem [64];
  logic [31:0] rdata_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) macro_mem[i] <= pat(i);
      rdata_q <= '0;
    end else if (dccm_en) begin
      if (dccm_we) begin
        for (int b = 0; b < 4; b++)
          if (dccm_wmask[b]) macro_mem[dccm_addr[5:0]][8*b +: 8] <= dccm_wdata[8*b +: 8];
      end else begin
        rdata_q <= macro_mem[dccm_addr[5:0]];
      end
    end
  end
  assign dccm_rdata = rdata_q;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [64];
  int          streak;
  logic        exp_lv, exp_dv;
  logic [31:0] exp_lr, exp_dr;
  logic        last_lg, last_dg;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    logic        forced, e_lrdy, e_drdy, lg, dg, e_en, e_we;
    logic [15:0] e_addr;
    logic [3:0]  e_mask;
    logic [31:0] e_wd;
    #1;
    lg = 1'b0; dg = 1'b0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_mask = '0; e_wd = '0;
    if (!rst_n) begin
      streak = 0;
      exp_lv = 1'b0; exp_dv = 1'b0; exp_lr = '0; exp_dr = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    end else begin
      forced = (streak >= SMAX);
      e_lrdy = !forced;
      e_drdy = forced || !lsu_req_valid;
      chk("lsu_ready", 32'(lsu_req_ready), 32'(e_lrdy));
      chk("dma_ready", 32'(dma_req_ready), 32'(e_drdy));
      lg = lsu_req_valid && e_lrdy;
      dg = dma_req_valid && e_drdy && !lg;
      if (lg) begin
        e_en = 1'b1; e_we = lsu_req_we; e_addr = lsu_req_addr;
        e_mask = lsu_req_we ? lsu_req_wmask : 4'h0; e_wd = lsu_req_wdata;
      end else if (dg) begin
        e_en = 1'b1; e_we = dma_req_we; e_addr = dma_req_addr;
        e_mask = dma_req_we ? dma_req_wmask : 4'h0; e_wd = dma_req_wdata;
      end
    end
    chk("dccm_en",    32'(dccm_en),    32'(e_en));
    chk("dccm_we",    32'(dccm_we),    32'(e_we));
    chk("dccm_addr",  32'(dccm_addr),  32'(e_addr));
    chk("dccm_wmask", 32'(dccm_wmask), 32'(e_mask));
    chk("dccm_wdata", dccm_wdata, e_wd);
    chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(exp_lv));
    chk("lsu_rsp_rdata", lsu_rsp_rdata, exp_lr);
    chk("dma_rsp_valid", 32'(dma_rsp_valid), 32'(exp_dv));
    chk("dma_rsp_rdata", dma_rsp_rdata, exp_dr);
    last_lg = lg;
    last_dg = dg;
  endtask

  task automatic apply(logic we, logic [15:0] addr, logic [3:0] mask, logic [31:0] wd,
                       output logic [31:0] rsp);
    rsp = we ? 32'h0 : ref_mem[addr[5:0]];
    if (we)
      for (int b = 0; b < 4; b++)
        if (mask[b]) ref_mem[addr[5:0]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      if (last_dg || !dma_req_valid) streak = 0;
      else if (streak < 255) streak++;
      exp_lv = last_lg; exp_dv = last_dg; exp_lr = '0; exp_dr = '0;
      if (last_lg) apply(lsu_req_we, lsu_req_addr, lsu_req_wmask, lsu_req_wdata, exp_lr);
      if (last_dg) apply(dma_req_we, dma_req_addr, dma_req_wmask, dma_req_wdata, exp_dr);
    end
    @(negedge clk);
  endtask

  task automatic rand_lsu();
    lsu_req_we    = 1'($urandom_range(0, 1));
    lsu_req_addr  = 16'($urandom_range(0, 63));
    lsu_req_wmask = 4'($urandom);
    lsu_req_wdata = $urandom;
  endtask

  task automatic rand_dma();
    dma_req_we    = 1'($urandom_range(0, 1));
    dma_req_addr  = 16'($urandom_range(0, 63));
    dma_req_wmask = 4'($urandom);
    dma_req_wdata = $urandom;
  endtask

  initial begin
    rst_n = 1'b0;
    lsu_req_valid = 1'b1; dma_req_valid = 1'b0;
    rand_lsu(); rand_dma();
    exp_lv = 1'b0; exp_dv = 1'b0; exp_lr = '0; exp_dr = '0; streak = 0;

    // Reset with an LSU request pending: the macro must stay quiet.
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("rst_dccm_en", 32'(dccm_en), 0);
      advance();
    end
    rst_n = 1'b1; lsu_req_valid = 1'b0;
    sample();
    chk("idle_lsu_ready", 32'(lsu_req_ready), 1);
    chk("idle_dma_ready", 32'(dma_req_ready), 1);
    chk("idle_rsp", 32'(lsu_rsp_valid | dma_rsp_valid), 0);
    advance();

    // LSU write then read back.
    lsu_req_valid = 1'b1; lsu_req_we = 1'b1; lsu_req_addr = 16'h0010;
    lsu_req_wmask = 4'hF; lsu_req_wdata = 32'hDEADBEEF;
    sample();
    chk("wr_en", 32'(dccm_en), 1);
    chk("wr_we", 32'(dccm_we), 1);
    advance();
    lsu_req_we = 1'b0;
    sample();
    chk("wr_rsp_valid", 32'(lsu_rsp_valid), 1);
    chk("wr_rsp_rdata", lsu_rsp_rdata, 32'h0);
    advance();
    lsu_req_valid = 1'b0;
    sample();
    chk("rd_rsp_valid", 32'(lsu_rsp_valid), 1);
    chk("rd_rsp_rdata", lsu_rsp_rdata, 32'hDEADBEEF);
    advance();

    // Starvation: DMA forced in cycle 8, LSU stalls once.
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 16'h0004;
    dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 16'h0008;
    dma_req_wmask = 4'hF; dma_req_wdata = 32'hCAFE0008;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (c < 8) begin
        chk("starve_lsu_ready", 32'(lsu_req_ready), 1);
        chk("starve_lsu_addr", 32'(dccm_addr), 32'h4);
      end else if (c == 8) begin
        chk("force_lsu_ready", 32'(lsu_req_ready), 0);
        chk("force_dma_addr", 32'(dccm_addr), 32'h8);
        chk("force_dma_we", 32'(dccm_we), 1);
      end else begin
        chk("after_dma_rsp", 32'(dma_rsp_valid), 1);
        chk("after_lsu_ready", 32'(lsu_req_ready), 1);
        chk("after_lsu_addr", 32'(dccm_addr), 32'h4);
      end
      advance();
      if (c == 8) dma_req_valid = 1'b0;
    end
    lsu_req_valid = 1'b0;
    sample(); advance();

    // DMA withdraws at count 7, returns later: LSU never stalls here.
    lsu_req_valid = 1'b1; dma_req_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 7)  dma_req_valid = 1'b0;
      if (c == 10) dma_req_valid = 1'b1;
      sample();
      chk("withdraw_lsu_ready", 32'(lsu_req_ready), 1);
      advance();
    end
    lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
    sample(); advance();

    // DMA byte write merge.
    dma_req_valid = 1'b1; dma_req_we = 1'b1; dma_req_addr = 16'h0020;
    dma_req_wmask = 4'hF; dma_req_wdata = 32'h11223344;
    sample(); advance();
    dma_req_wmask = 4'h2; dma_req_wdata = 32'h0000AB00;
    sample(); advance();
    dma_req_we = 1'b0;
    sample(); advance();
    dma_req_valid = 1'b0;
    sample();
    chk("byte_rsp_valid", 32'(dma_rsp_valid), 1);
    chk("byte_rsp_rdata", dma_rsp_rdata, 32'h1122AB44);
    advance();

    // Reset the cycle after a read grant drops the response.
    lsu_req_valid = 1'b1; lsu_req_we = 1'b0; lsu_req_addr = 16'h0010;
    sample(); advance();
    rst_n = 1'b0; lsu_req_valid = 1'b0;
    sample();
    chk("midrst_rsp", 32'(lsu_rsp_valid), 0);
    advance();
    sample(); advance();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sample();
      chk("postrst_rsp", 32'(lsu_rsp_valid | dma_rsp_valid), 0);
      chk("postrst_lsu_ready", 32'(lsu_req_ready), 1);
      chk("postrst_dma_ready", 32'(dma_req_ready), 1);
      advance();
    end

    // Randomized traffic; requesters hold fields while waiting, DMA may withdraw.
    for (int c = 0; c < 3000; c++) begin
      sample();
      advance();
      if (!(lsu_req_valid && !last_lg)) begin
        lsu_req_valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 85 : 40));
        rand_lsu();
      end
      if (dma_req_valid && !last_dg) begin
        if ($urandom_range(0, 99) < 6) dma_req_valid = 1'b0;
      end else begin
        dma_req_valid = ($urandom_range(0, 99) < 45);
        rand_dma();
      end
    end
    lsu_req_valid = 1'b0; dma_req_valid = 1'b0;
    sample(); advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dccm_arbiter.md
# dccm_arbiter

Arbitrates the single-port DCCM between two requesters: the LSU (DC1 issue point) and an external DMA/debug loader that preloads and inspects data memory. The LSU has fixed priority; a starvation counter guarantees the DMA a grant after `STARVE_MAX` consecutive denied cycles. A registered response path returns read data or write acknowledges to the owning requester one cycle after grant. The arbiter sits between `lsu` and the DCCM macro inside `exu`/`core_top`.

## Interface
- `XLEN`, 32, data width; byte mask width is `XLEN/8`
- `DCCM_ADDR_W`, 16, word-address width into the DCCM
- `STARVE_MAX`, 8, number of consecutive denied DMA cycles before DMA is forced (range 1..255)
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `lsu_req_valid` / `lsu_req_ready`  in / out  1  LSU request handshake
- `lsu_req_we`  in  1  1 = write, 0 = read
- `lsu_req_addr`  in  DCCM_ADDR_W  word address
- `lsu_req_wmask`  in  XLEN/8  byte write enables
- `lsu_req_wdata`  in  XLEN  write data
- `lsu_rsp_valid`  out  1  response for the LSU request granted last cycle
- `lsu_rsp_rdata`  out  XLEN  read data; 0 for writes
- `dma_req_valid`, `dma_req_ready`, `dma_req_we`, `dma_req_addr`, `dma_req_wmask`, `dma_req_wdata`: same widths and meanings as the LSU set
- `dma_rsp_valid`, `dma_rsp_rdata`: same widths and meanings as the LSU set
- `dccm_en`  out  1  memory access strobe
- `dccm_we`  out  1  memory write
- `dccm_addr`  out  DCCM_ADDR_W  memory address
- `dccm_wmask`  out  XLEN/8  memory byte enables
- `dccm_wdata`  out  XLEN  memory write data
- `dccm_rdata`  in  XLEN  memory read data, valid one cycle after `dccm_en`

## Operation
- Grant: a request is granted when `*_req_valid & *_req_ready`. At most one grant per cycle. `*_req_ready` is combinational from the state and the other requester's valid.
- FSM `arb_state`:
  - `ARB_LSU_PRI` (reset): `lsu_req_ready = 1`; `dma_req_ready = !lsu_req_valid`.
  - `ARB_DMA_FORCE`: `dma_req_ready = 1`; `lsu_req_ready = 0`.
  - `LSU_PRI -> DMA_FORCE` when the starvation count reaches `STARVE_MAX`. `DMA_FORCE -> LSU_PRI` on DMA grant, or when `dma_req_valid` drops (DMA withdrew).
- Starvation counter, 8 bits, saturating:
  - Increments each cycle with `dma_req_valid & !dma grant`.
  - Clears on DMA grant or when `!dma_req_valid`.
- DCCM drive: `dccm_en` = any grant. Address, mask, data and `we` are muxed from the granted requester. `dccm_wmask` is forced to 0 on reads. All `dccm_*` outputs are 0 when there is no grant.
- Response: on grant, register `rsp_owner` (LSU/DMA), `rsp_pend = 1` and `rsp_is_read`.
  - Next cycle, the owner's `*_rsp_valid = 1`.
  - `*_rsp_rdata = dccm_rdata` if read, else 0.
  - The non-owner's response is 0.
- Back-to-back grants are allowed every cycle; the response pipeline is one deep and is overwritten each cycle.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - state `ARB_LSU_PRI`, counter 0, `rsp_pend = 0`.
  - All `*_rsp_valid`/`*_rsp_rdata` = 0.
  - `dccm_*` = 0 while `rst_n` is low.
- Latency: request at cycle N, response valid at N+1. No responses are ever combinational with a request.
- Forced DMA: with LSU continuously valid and DMA valid from cycle 0:
  - Counter reaches `STARVE_MAX` at end of cycle `STARVE_MAX-1`.
  - State becomes `DMA_FORCE` in cycle `STARVE_MAX`; DMA is granted that cycle and the LSU stalls exactly one cycle.
- Simultaneous events:
  - Both valid in `LSU_PRI` -> LSU wins.
  - Counter reaching `STARVE_MAX` in the same cycle DMA withdraws -> counter clears and state stays `LSU_PRI`.
- Reset mid-operation: the pending response is dropped; no `rsp_valid` appears after reset release.
- A requester must hold request fields stable while valid and not ready.

## Structure
- Shared core package: `dccm_req_t` struct (`we`, `addr`, `wmask`, `wdata`), `arb_state_e` enum (`ARB_LSU_PRI`, `ARB_DMA_FORCE`), and `DCCM_ARB_STARVE_MAX` default constant.
- One sub-module: `dccm_arb_starve_ctr` (saturating counter with clear/inc and a threshold-reached output).
- Requester mux and response pipeline stay in `dccm_arbiter`.

## Test plan
- Reset then idle: all outputs 0; `lsu_req_ready = 1`, `dma_req_ready = 1`.
- LSU write addr 0x0010, wdata 0xDEADBEEF, wmask 0xF:
  - `dccm_en = dccm_we = 1` in the same cycle.
  - Next cycle `lsu_rsp_valid = 1`, rdata 0.
  - Then an LSU read of 0x0010 returns `lsu_rsp_rdata = 0xDEADBEEF` one cycle later.
- Both valid (LSU read 0x4, DMA write 0x8, `STARVE_MAX = 8`) with LSU held valid:
  - LSU is granted for 8 cycles.
  - DMA is granted in cycle 8 with `lsu_req_ready = 0` for that cycle only.
  - `dma_rsp_valid = 1` at cycle 9; LSU is granted again at cycle 9.
- DMA withdraws at count 7 (`STARVE_MAX = 8`): the counter clears, there is no `DMA_FORCE`, and the LSU is never stalled.
- Byte write: DMA write mask 0x2, data 0x0000AB00 over existing 0x11223344 -> a subsequent read returns 0x1122AB44.
- Assert `rst_n = 0` the cycle after a read grant: no `*_rsp_valid` at any time after release, and the state is `ARB_LSU_PRI`.
